fc_stream_feeder: RTL
=====================

# fc_stream_feeder

Sequencer that streams one fully-connected layer into the FC core's `din_valid`/`din_data` port. It reads activations, weights and biases from a word-addressed on-chip SRAM with 1-cycle read latency and emits them in the exact order and phase framing the FC core consumes. It sits between the layer-descriptor logic and the FC core, on the core's input side.

## Interface
- `AW`, 16: memory word-address width.
- `DW`, 16: data width; Q5.10 fixed point, matching the FC core.
- `CW`, 12: width of `cin`/`cout`.
---
- `clk`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `start`  in  1  single-cycle launch pulse; sampled only in IDLE.
- `cin`  in  CW  input length; sampled at `start`.
- `cout`  in  CW  output length; sampled at `start`.
- `has_bias`  in  1  1 = read biases from memory, 0 = send zeros; sampled at `start`.
- `in_base`, `w_base`, `b_base`  in  AW each  base word addresses; sampled at `start`.
- `mem_addr`  out  AW  SRAM read address.
- `mem_ren`  out  1  SRAM read enable.
- `mem_rdata`  in  DW  read data, valid one cycle after `mem_ren`.
- `dout_valid`  out  1  beat valid, to FC core `din_valid`.
- `dout_data`  out  DW  beat data, to FC core `din_data`.
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle.
- `done`  out  1  single-cycle pulse, the cycle after the last bias beat.

## Operation
- States: IDLE, INPUT, GAP0, WEIGHT, GAP1, BIAS, GAP2, DONE.
- Reset values: all outputs 0; state is IDLE; all counters are 0.
- IDLE + `start`: latch the descriptor, then go to INPUT. `start` is ignored in every state other than IDLE.
- INPUT: reads `in_base+0 … in_base+cin-1` → `cin` beats.
- WEIGHT: reads `w_base+k` for k = 0 … cin·cout−1, output-major (k = o·cin + i) → cin·cout beats.
  - Uses a 2·CW-bit counter. Address arithmetic wraps modulo 2^AW.
- BIAS: cout beats.
  - `has_bias`=1: data from `b_base+o`.
  - `has_bias`=0: `mem_ren` stays 0 and the beats carry 0x0000.
- GAPn: exactly one cycle with `dout_valid`=0 between phases. This is required because the FC core ignores `din` on its phase-transition cycle.
- DONE: pulse `done`, then return to IDLE.
- No backpressure exists. `dout_valid` beats within a phase are contiguous, one per cycle, with no holes.
- `cin`=0 or `cout`=0: no memory reads and no beats; `done` fires 2 cycles after `start`.
- `rst` mid-layer: the next cycle returns to IDLE with `dout_valid`=`mem_ren`=`busy`=0. Any in-flight read data is discarded.

## Timing
- `start` high in cycle T:
  - First `mem_ren` in T+1.
  - `mem_rdata` returns in T+2.
  - Registered to `dout_*`, so the first input beat is in T+3.
- Read→beat latency is 2 cycles. Reads are issued back-to-back, and the read pipeline runs ahead across the gaps.
- Beat schedule, with N = cin·cout:
  - Input beats: T+3 … T+2+cin.
  - Gap: T+3+cin.
  - Weight beats: T+4+cin … T+3+cin+N.
  - Gap: T+4+cin+N.
  - Bias beats: T+5+cin+N … T+4+cin+N+cout.
  - Gap and `done`: T+5+cin+N+cout.
- `busy` falls the cycle after `done`. A new `start` is accepted in that cycle.
- `dout_data` holds its last value when `dout_valid`=0. Consumers must not rely on that value.

## Structure
- Shared package `fc_pkg`:
  - phase enum (INPUT/WEIGHT/BIAS);
  - `FC_DW`=16 and `FC_CW`=12;
  - Q5.10 fraction-bits constant (10).
  - The FC core and its output-collector block share this package.
- One sub-module, `fc_read_pipe`. It holds the 1-deep read-tracking register (valid plus zero-substitute flag) and the output data register, and keeps the `dout` alignment logic out of the FSM.
- The FSM and address/beat counters live in `fc_stream_feeder`.

## Test plan
- cin=2, cout=3, has_bias=1, memory word = its address:
  - Beats: 2 input, gap, 6 weight (w_base…w_base+5 in order), gap, 3 bias, then `done`.
  - Total of 11 beats; `done` at T+16.
- Same descriptor with has_bias=0:
  - Bias beats are 0x0000 and no reads target `b_base`.
- End to end with an FC core model, cin=4, cout=2, Q5.10 weights 1.0 (0x0400), inputs 1..4, biases −1:
  - Core outputs (10−1)=9 for both.
  - Negative sums are clamped to 0 by the core.
- cout=0: no `mem_ren`, no beats, `done` 2 cycles after `start`; `start` pulses while `busy` are ignored.
- `rst` asserted mid-WEIGHT: the next cycle has `dout_valid`=0 and `busy`=0. A new `start` then produces a clean layer from the INPUT phase.
- `w_base`=0xFFFE, N=4: addresses wrap to 0xFFFE, 0xFFFF, 0x0000, 0x0001.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared FC-layer definitions: data/length widths, Q5.10 format constant,
// streaming phase encoding and the feeder's sequencing states.
package fc_pkg;

  localparam int FC_DW        = 16;
  localparam int FC_CW        = 12;
  localparam int FC_FRAC_BITS = 10;

  typedef enum logic [1:0] {
    PH_INPUT  = 2'd0,
    PH_WEIGHT = 2'd1,
    PH_BIAS   = 2'd2
  } fc_phase_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INPUT  = 3'd1,
    ST_GAP0   = 3'd2,
    ST_WEIGHT = 3'd3,
    ST_GAP1   = 3'd4,
    ST_BIAS   = 3'd5,
    ST_GAP2   = 3'd6,
    ST_DONE   = 3'd7
  } feed_state_e;

  // Phase whose base address a state reads from; non-reading states map to INPUT.
  function automatic fc_phase_e phase_of(feed_state_e s);
    fc_phase_e ph;
    case (s)
      ST_WEIGHT: ph = PH_WEIGHT;
      ST_BIAS:   ph = PH_BIAS;
      default:   ph = PH_INPUT;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/fc_read_pipe.sv
// Read-tracking and output alignment: follows each issued read (or zero
// substitute) through the 1-cycle SRAM latency and registers it onto dout.
module fc_read_pipe #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic              issue_zero,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dout_valid,
  output logic [DATA_W-1:0] dout_data
);

  logic              vld_p0;
  logic              zero_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;

  // Stage p0: remember that a beat is due when the SRAM answers next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      zero_p0 <= 1'b0;
    end else begin
      vld_p0  <= issue;
      zero_p0 <= issue_zero;
    end
  end

  // Stage p1: capture read data (or zero) as the beat; data holds between beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        data_p1 <= zero_p0 ? '0 : mem_rdata;
      end
    end
  end

  assign dout_valid = vld_p1;
  assign dout_data  = data_p1;

endmodule

// File: rtl/fc_stream_feeder.sv
// Streams one FC layer (inputs, weights, biases) from SRAM into the FC core,
// with one idle cycle between phases. The FSM runs two cycles ahead of the
// beats because of the SRAM latency plus the output register.
module fc_stream_feeder
  import fc_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = FC_DW,
  parameter int CW = FC_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] cin,
  input  logic [CW-1:0] cout,
  input  logic          has_bias,
  input  logic [AW-1:0] in_base,
  input  logic [AW-1:0] w_base,
  input  logic [AW-1:0] b_base,
  output logic [AW-1:0] mem_addr,
  output logic          mem_ren,
  input  logic [DW-1:0] mem_rdata,
  output logic          dout_valid,
  output logic [DW-1:0] dout_data,
  output logic          busy,
  output logic          done
);

  localparam int WW = 2 * CW;

  feed_state_e   state, state_next;

  logic [CW-1:0] cin_q;
  logic [CW-1:0] cout_q;
  logic [WW-1:0] nw_q;
  logic          has_bias_q;
  logic [AW-1:0] in_base_q;
  logic [AW-1:0] w_base_q;
  logic [AW-1:0] b_base_q;

  logic [WW-1:0] idx;
  logic [WW-1:0] last_idx;
  logic          idx_last;
  logic          accept;
  logic          issue;
  logic          zero_sub;
  logic          rd_en;
  logic [AW-1:0] base;

  // A start is taken only when fully idle, including the done cycle.
  assign accept   = (state == ST_IDLE) && start && !busy;
  assign issue    = (state == ST_INPUT) || (state == ST_WEIGHT) || (state == ST_BIAS);
  assign zero_sub = (state == ST_BIAS) && !has_bias_q;
  assign rd_en    = issue && !zero_sub;
  assign idx_last = (idx == last_idx);

  // Final index of the phase currently being read.
  always_comb begin
    last_idx = '0;
    case (state)
      ST_INPUT:  last_idx = WW'(cin_q) - WW'(1);
      ST_WEIGHT: last_idx = nw_q - WW'(1);
      ST_BIAS:   last_idx = WW'(cout_q) - WW'(1);
      default:   last_idx = '0;
    endcase
  end

  // Base address of the current phase; address arithmetic wraps at 2^AW.
  always_comb begin
    base = in_base_q;
    case (phase_of(state))
      PH_WEIGHT: base = w_base_q;
      PH_BIAS:   base = b_base_q;
      default:   base = in_base_q;
    endcase
  end

  assign mem_ren  = rd_en;
  assign mem_addr = rd_en ? (base + AW'(idx)) : '0;

  // Next-state sequencing: phases separated by single gap states.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if ((cin == '0) || (cout == '0)) state_next = ST_DONE;
          else                             state_next = ST_INPUT;
        end
      end
      ST_INPUT:  if (idx_last) state_next = ST_GAP0;
      ST_GAP0:   state_next = ST_WEIGHT;
      ST_WEIGHT: if (idx_last) state_next = ST_GAP1;
      ST_GAP1:   state_next = ST_BIAS;
      ST_BIAS:   if (idx_last) state_next = ST_GAP2;
      ST_GAP2:   state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Per-phase read index: counts reads, clears at the end of each phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (issue && !idx_last) begin
      idx <= idx + WW'(1);
    end else begin
      idx <= '0;
    end
  end

  // Descriptor capture on an accepted start.
  always_ff @(posedge clk) begin
    if (accept) begin
      cin_q      <= cin;
      cout_q     <= cout;
      nw_q       <= WW'(cin) * WW'(cout);
      has_bias_q <= has_bias;
      in_base_q  <= in_base;
      w_base_q   <= w_base;
      b_base_q   <= b_base;
    end
  end

  // Status: busy spans the layer through the done cycle; done trails DONE state
  // by one cycle so it lands right after the last bias beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next != ST_IDLE) || (state == ST_DONE);
      done <= (state == ST_DONE);
    end
  end

  fc_read_pipe #(
    .DATA_W(DW)
  ) u_read_pipe (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .issue_zero (zero_sub),
    .mem_rdata  (mem_rdata),
    .dout_valid (dout_valid),
    .dout_data  (dout_data)
  );

endmodule
